// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch increment, jumps, calls/returns, exceptions and halt.
// Optional return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h0000_0100),
  parameter int unsigned      INC       = 4,
  parameter logic [4:0]       PH_FETCH  = 5'b00001,
  parameter int unsigned      RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [4:0]       phase,
  input  logic             stall,
  input  logic             ct_taken,
  input  logic [WIDTH-1:0] target,
  input  logic             call,
  input  logic             ret,
  input  logic             exc,
  input  logic             hlt,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] epc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             is_fetch;

  assign is_fetch = (phase == PH_FETCH);

`ifdef PC_SEQ_RAS_EN
  localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  // ptr_q is the next write slot; when full it also points at the oldest entry,
  // so a push in that state overwrites the oldest return address.
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d, ptr_inc, ptr_dec;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             push_en;
  logic             full_w, empty_w;

  assign full_w  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty_w = (cnt_q == '0);
  assign ptr_inc = (ptr_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_dec = (ptr_q == '0) ? PTR_W'(RAS_DEPTH - 1) : ptr_q - PTR_W'(1);
`else
  logic unused_cfg;
  assign unused_cfg = ^{call, ret, RAS_DEPTH[0]};
`endif

  always_comb begin
    pc_d  = pc_q;
    epc_d = epc_q;
`ifdef PC_SEQ_RAS_EN
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_en = 1'b0;
`endif
    if (hlt) begin
      pc_d = RESET_VEC;
`ifdef PC_SEQ_RAS_EN
      ptr_d = '0;
      cnt_d = '0;
      err_d = 1'b0;
`endif
    end else if (exc) begin
      epc_d = pc_q;
      pc_d  = EXC_VEC;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (is_fetch) begin
      pc_d = pc_q + WIDTH'(INC);
    end else if (ct_taken) begin
      pc_d = target;
`ifdef PC_SEQ_RAS_EN
      if (ret) begin
        if (!empty_w) begin
          pc_d  = ras_q[ptr_dec];
          ptr_d = ptr_dec;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (call) begin
        push_en = 1'b1;
        ptr_d   = ptr_inc;
        if (full_w) err_d = 1'b1;
        else        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
    end
  end

`ifdef PC_SEQ_RAS_EN
  always_comb begin
    for (int i = 0; i < int'(RAS_DEPTH); i++) ras_d[i] = ras_q[i];
    if (push_en) ras_d[ptr_q] = pc_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= ras_d[i];
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign ras_empty = empty_w;
  assign ras_full  = full_w;
  assign ras_err   = err_q;
`else
  assign ras_empty = 1'b1;
  assign ras_full  = 1'b0;
  assign ras_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pc_q  <= RESET_VEC;
      epc_q <= '0;
    end else begin
      pc_q  <= pc_d;
      epc_q <= epc_d;
    end
  end

  assign pc  = pc_q;
  assign epc = epc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer; expectations adapt to whether PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif
  localparam logic [4:0] F = 5'b00001;
  localparam logic [4:0] I = 5'b00010;

  typedef struct packed {
    logic        hlt, exc, stall;
    logic [4:0]  ph;
    logic        ct, call, ret;
    logic [31:0] tgt, pc, epc;
    logic        em, fu, er;
  } vec_t;

  logic        clk, n_rst;
  logic [4:0]  phase;
  logic        stall, ct_taken, call, ret, exc, hlt;
  logic [31:0] target, pc, epc;
  logic        ras_empty, ras_full, ras_err;

  logic [4:0]  phase8;
  logic        stall8, ct8, call8, ret8, exc8, hlt8;
  logic [7:0]  target8, pc8, epc8;
  logic        em8, fu8, er8;

  int n_vec = 0;
  int n_bad = 0;
  vec_t v[$];

  pc_sequencer dut (
    .clk(clk), .n_rst(n_rst), .phase(phase), .stall(stall), .ct_taken(ct_taken),
    .target(target), .call(call), .ret(ret), .exc(exc), .hlt(hlt),
    .pc(pc), .epc(epc), .ras_empty(ras_empty), .ras_full(ras_full), .ras_err(ras_err)
  );

  pc_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .phase(phase8), .stall(stall8), .ct_taken(ct8),
    .target(target8), .call(call8), .ret(ret8), .exc(exc8), .hlt(hlt8),
    .pc(pc8), .epc(epc8), .ras_empty(em8), .ras_full(fu8), .ras_err(er8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [31:0] e_pc, input logic [31:0] e_epc,
                         input logic e_em, input logic e_fu, input logic e_er);
    chk({nm, " pc"}, pc, e_pc);
    chk({nm, " epc"}, epc, e_epc);
    chk({nm, " flags"}, {29'd0, ras_empty, ras_full, ras_err}, {29'd0, e_em, e_fu, e_er});
  endtask

  function automatic vec_t mk(input logic h, input logic x, input logic s, input logic [4:0] p,
                              input logic c, input logic cl, input logic r, input logic [31:0] t,
                              input logic [31:0] epc_v, input logic [31:0] eepc,
                              input logic em, input logic fu, input logic er);
    vec_t r_v;
    r_v.hlt = h; r_v.exc = x; r_v.stall = s; r_v.ph = p;
    r_v.ct = c; r_v.call = cl; r_v.ret = r; r_v.tgt = t;
    r_v.pc = epc_v; r_v.epc = eepc; r_v.em = em; r_v.fu = fu; r_v.er = er;
    return r_v;
  endfunction

  task automatic drive(input vec_t x);
    hlt = x.hlt; exc = x.exc; stall = x.stall; phase = x.ph;
    ct_taken = x.ct; call = x.call; ret = x.ret; target = x.tgt;
  endtask

  initial begin
    n_rst = 1'b0;
    drive(mk(0,0,0,I,0,0,0,0, 0,0,1,0,0));
    phase8 = I; stall8 = 0; ct8 = 0; call8 = 0; ret8 = 0; exc8 = 0; hlt8 = 0; target8 = 8'h00;

    // fetch sequence, call/return round trip
    v.push_back(mk(0,0,0,F,0,0,0,0,        32'd4,   0, 1,0,0));
    v.push_back(mk(0,0,0,F,0,0,0,0,        32'd8,   0, 1,0,0));
    v.push_back(mk(0,0,0,F,0,0,0,0,        32'd12,  0, 1,0,0));
    v.push_back(mk(0,0,0,I,1,1,0,32'h200,  32'h200, 0, !RAS,0,0));
    v.push_back(mk(0,0,0,F,0,0,0,0,        32'h204, 0, !RAS,0,0));
    v.push_back(mk(0,0,0,I,1,0,1,32'h999,  RAS ? 32'd12 : 32'h999, 0, 1,0,0));
    v.push_back(mk(0,0,0,I,1,0,1,32'h80,   32'h80,  0, 1,0,RAS));
    v.push_back(mk(1,0,0,I,0,0,0,0,        32'h0,   0, 1,0,0));
    // overflow: five pushes into a four-entry stack, then five pops
    v.push_back(mk(0,0,0,I,1,0,0,32'h10,   32'h10,  0, 1,0,0));
    v.push_back(mk(0,0,0,I,1,1,0,32'h20,   32'h20,  0, !RAS,0,0));
    v.push_back(mk(0,0,0,I,1,1,0,32'h30,   32'h30,  0, !RAS,0,0));
    v.push_back(mk(0,0,0,I,1,1,0,32'h40,   32'h40,  0, !RAS,0,0));
    v.push_back(mk(0,0,0,I,1,1,0,32'h50,   32'h50,  0, !RAS,RAS,0));
    v.push_back(mk(0,0,0,I,1,1,0,32'h60,   32'h60,  0, !RAS,RAS,RAS));
    v.push_back(mk(0,0,0,I,1,0,1,32'h77,   RAS ? 32'h50 : 32'h77, 0, !RAS,0,RAS));
    v.push_back(mk(0,0,0,I,1,0,1,32'h77,   RAS ? 32'h40 : 32'h77, 0, !RAS,0,RAS));
    v.push_back(mk(0,0,0,I,1,0,1,32'h77,   RAS ? 32'h30 : 32'h77, 0, !RAS,0,RAS));
    v.push_back(mk(0,0,0,I,1,0,1,32'h77,   RAS ? 32'h20 : 32'h77, 0, 1,0,RAS));
    v.push_back(mk(0,0,0,I,1,0,1,32'h77,   32'h77,  0, 1,0,RAS));
    // exception and halt
    v.push_back(mk(0,0,0,I,1,0,0,32'h40,   32'h40,  0, 1,0,RAS));
    v.push_back(mk(0,0,0,F,0,0,0,0,        32'h44,  0, 1,0,RAS));
    v.push_back(mk(0,1,0,F,0,0,0,0,        32'h100, 32'h44, 1,0,RAS));
    v.push_back(mk(1,1,0,I,0,0,0,0,        32'h0,   32'h44, 1,0,0));
    // stall, qualifiers without ct_taken, ct_taken during fetch
    v.push_back(mk(0,0,0,F,0,0,0,0,        32'd4,   32'h44, 1,0,0));
    v.push_back(mk(0,0,1,F,1,0,0,32'h300,  32'd4,   32'h44, 1,0,0));
    v.push_back(mk(0,0,0,I,0,1,0,32'h300,  32'd4,   32'h44, 1,0,0));
    v.push_back(mk(0,0,0,I,0,0,1,32'h300,  32'd4,   32'h44, 1,0,0));
    v.push_back(mk(0,0,0,F,1,0,0,32'h300,  32'd8,   32'h44, 1,0,0));
    // stall and exception leave the stack intact
    v.push_back(mk(0,0,0,I,1,1,0,32'h500,  32'h500, 32'h44, !RAS,0,0));
    v.push_back(mk(0,0,1,I,1,0,1,32'h111,  32'h500, 32'h44, !RAS,0,0));
    v.push_back(mk(0,0,0,I,1,0,1,32'h600,  RAS ? 32'd8 : 32'h600, 32'h44, 1,0,0));
    v.push_back(mk(0,0,0,I,1,1,0,32'h700,  32'h700, 32'h44, !RAS,0,0));
    v.push_back(mk(0,1,0,I,0,0,0,0,        32'h100, 32'h700, !RAS,0,0));
    v.push_back(mk(0,0,0,I,1,0,1,32'h900,  RAS ? 32'd8 : 32'h900, 32'h700, 1,0,0));
    v.push_back(mk(0,0,0,I,1,0,1,32'h20,   32'h20,  32'h700, 1,0,RAS));

    #3;
    chk_all("reset", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("reset pc8", {24'd0, pc8}, 32'h0);
    #4 n_rst = 1'b1;

    for (int i = 0; i < v.size(); i++) begin
      @(negedge clk);
      drive(v[i]);
      @(posedge clk);
      #1;
      chk_all($sformatf("v%0d", i), v[i].pc, v[i].epc, v[i].em, v[i].fu, v[i].er);
    end

    // 8-bit wrap-around
    @(negedge clk);
    drive(mk(0,0,0,I,0,0,0,0, 0,0,1,0,0));
    ct8 = 1'b1; target8 = 8'hFC;
    @(posedge clk); #1;
    chk("w8 load", {24'd0, pc8}, 32'hFC);
    @(negedge clk);
    ct8 = 1'b0; phase8 = F;
    @(posedge clk); #1;
    chk("w8 wrap", {24'd0, pc8}, 32'h00);
    @(negedge clk);
    @(posedge clk); #1;
    chk("w8 next", {24'd0, pc8}, 32'h04);
    @(negedge clk);
    phase8 = I;

    // async reset mid-cycle discards the pending fetch
    drive(mk(0,0,0,F,0,0,0,0, 0,0,1,0,0));
    @(posedge clk); #2;
    n_rst = 1'b0;
    #1;
    chk_all("async rst", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("rst hold", pc, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #1;
    chk("first after rst", pc, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning PC and target width in bits.
REQ-002 The block SHALL have parameter RESET_VEC, default 0, meaning the PC value loaded on reset and halt.
REQ-003 The block SHALL have parameter EXC_VEC, default 32'h0000_0100, meaning the PC value loaded on an exception.
REQ-004 The block SHALL have parameter INC, default 4, meaning the fetch increment.
REQ-005 The block SHALL have parameter PH_FETCH, default 5'b00001, meaning the phase code of the fetch phase.
REQ-006 The block SHALL have parameter RAS_DEPTH, default 4 (legal range 2..16), meaning the number of return-address-stack entries.
REQ-007 The block SHALL have ports, one per line:
- clk  in  1  clock; all state updates on the rising edge
- n_rst  in  1  asynchronous active-low reset
- phase  in  5  current CPU phase code
- stall  in  1  freeze PC and stack this cycle
- ct_taken  in  1  control transfer taken
- target  in  WIDTH  branch/jump target
- call  in  1  qualifies ct_taken as a call
- ret  in  1  qualifies ct_taken as a return
- exc  in  1  exception request
- hlt  in  1  halt; restart at RESET_VEC
- pc  out  WIDTH  current program counter (registered)
- epc  out  WIDTH  PC captured at the last exception (registered)
- ras_empty  out  1  stack holds 0 entries
- ras_full  out  1  stack holds RAS_DEPTH entries
- ras_err  out  1  sticky overflow/underflow flag

Function
REQ-008 The block SHALL apply exactly one action per rising clk edge, in this priority order: hlt, exc, stall, fetch, transfer.
REQ-009 hlt SHALL load pc with RESET_VEC, empty the stack and clear ras_err; epc SHALL be unchanged.
REQ-010 exc (without hlt) SHALL load epc with the current pc and pc with EXC_VEC; the stack SHALL be unchanged.
REQ-011 stall (without hlt/exc) SHALL hold pc, epc and the stack for that cycle, even during fetch phase or with ct_taken high.
REQ-012 phase == PH_FETCH SHALL load pc with pc + INC, modulo 2^WIDTH; ct_taken SHALL be ignored in that cycle.
REQ-013 ct_taken with call=0 and ret=0 SHALL load pc with target.
REQ-014 ct_taken with call=1 and ret=0 SHALL push the current pc (the return address) and load pc with target.
REQ-015 ct_taken with ret=1 and a non-empty stack SHALL pop the top entry into pc and ignore target; call SHALL be ignored when ret=1.
REQ-016 ct_taken with ret=1 and an empty stack SHALL load pc with target and set ras_err.
REQ-017 A push when full SHALL overwrite the oldest entry as a circular buffer, keep the count at RAS_DEPTH and set ras_err.
REQ-018 call and ret without ct_taken SHALL have no effect.
REQ-019 ras_empty and ras_full SHALL be combinational decodes of the registered entry count.
REQ-020 Once set, ras_err SHALL stay high until reset or hlt.

Reset
REQ-021 Assertion of n_rst low SHALL immediately set pc=RESET_VEC, epc=0, stack count=0, ras_err=0, ras_empty=1 and ras_full=0, regardless of clk.
REQ-022 Reset asserted mid-transfer SHALL discard the pending action; the first action after deassertion SHALL occur at the first rising clk edge with n_rst high.

Configuration
REQ-023 Macro PC_SEQ_RAS_EN SHALL select the stack feature.
REQ-024 With PC_SEQ_RAS_EN defined, the return-address stack and REQ-014 through REQ-020 SHALL be implemented.
REQ-025 With PC_SEQ_RAS_EN undefined:
- no stack storage SHALL be synthesised
- call and ret SHALL be ignored, so every ct_taken loads target
- ras_empty SHALL be 1, ras_full 0 and ras_err 0 constantly.

Verification
REQ-026 The bench SHALL cover: reset, then three fetch cycles -> pc = 0, 4, 8, 12.
REQ-027 The bench SHALL cover: pc=12, ct_taken=1, call=1, target=0x200 -> pc=0x200 with stack top 12; then fetch and ct_taken with ret=1 -> pc=0x204, then pc=12 with ras_empty=1.
REQ-028 The bench SHALL cover: RAS_DEPTH=4, five calls from pcs 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1 and ras_err=1; five returns -> pc 0x50, 0x40, 0x30, 0x20, then target on the fifth.
REQ-029 The bench SHALL cover: exc while pc=0x44 in fetch phase -> pc=0x100 and epc=0x44; exc and hlt together -> pc=0 and epc unchanged.
REQ-030 The bench SHALL cover: stall=1 with phase=PH_FETCH and ct_taken=1 -> pc unchanged; WIDTH=8, pc=0xFC, fetch -> pc=0x00.
REQ-031 The bench SHALL cover: build without PC_SEQ_RAS_EN, ct_taken with ret=1 and target=0x80 -> pc=0x80, ras_empty=1 and ras_err=0.
